// File: rtl/serial_addsub_n.sv
// Multi-word serial adder/subtractor.
// Two CHUNK_W*NUM_CHUNKS-bit operands arrive one chunk per accepted beat, LSB chunk first.
// A carry register links the slices, so the wide add or subtract is built up one slice at a time.
// Subtraction is A + ~B + 1: the carry register is seeded with the latched sub bit.
// done pulses for one cycle when the result and flags are ready.
// The result and flags then hold until the next start is accepted.
module serial_addsub_n #(
    parameter int CHUNK_W    = 12,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            sub,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CHUNK_W-1:0]              in_a,
    input  logic [CHUNK_W-1:0]              in_b,
    output logic [CHUNK_W*NUM_CHUNKS-1:0]   result,
    output logic                            done,
    output logic                            busy,
    output logic                            carry_out,
    output logic                            overflow
);

    localparam int RES_W = CHUNK_W * NUM_CHUNKS;
    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic               sub_r;
    logic               carry_r;
    logic [CNT_W-1:0]   count;
    logic [RES_W-1:0]   result_r;
    logic               carry_out_r;
    logic               overflow_r;

    logic [CHUNK_W-1:0] b_mod;
    logic [CHUNK_W:0]   sum;
    logic               slice_ovf;
    logic               beat;
    logic               last_beat;
    logic [RES_W-1:0]   result_next;

    // One slice of the wide operation: conditionally inverted B, chunk sum and signed-overflow term
    always_comb begin
        b_mod     = sub_r ? ~in_b : in_b;
        sum       = {1'b0, in_a} + {1'b0, b_mod} + {{CHUNK_W{1'b0}}, carry_r};
        slice_ovf = (in_a[CHUNK_W-1] == b_mod[CHUNK_W-1]) &&
                    (sum[CHUNK_W-1] != in_a[CHUNK_W-1]);
        beat      = (state == S_RUN) && in_valid;
        last_beat = (count == CNT_W'(NUM_CHUNKS - 1));
    end

    // New slices enter at the top and shift down, so after the last beat chunk k sits at k*CHUNK_W
    generate
        if (NUM_CHUNKS == 1) begin : g_single
            assign result_next = sum[CHUNK_W-1:0];
        end else begin : g_multi
            assign result_next = {sum[CHUNK_W-1:0], result_r[RES_W-1:CHUNK_W]};
        end
    endgenerate

    // Control FSM plus the datapath registers it owns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sub_r       <= 1'b0;
            carry_r     <= 1'b0;
            count       <= '0;
            result_r    <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RUN;
                        sub_r       <= sub;
                        carry_r     <= sub;
                        count       <= '0;
                        result_r    <= '0;
                        carry_out_r <= 1'b0;
                        overflow_r  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (beat) begin
                        result_r <= result_next;
                        carry_r  <= sum[CHUNK_W];
                        if (last_beat) begin
                            state       <= S_DONE;
                            carry_out_r <= sum[CHUNK_W];
                            overflow_r  <= slice_ovf ^ 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);
    assign result    = result_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Testbench for serial_addsub_n with a scoreboard.
// Two instances are driven: the default 12x4 build and an 8x2 build.
// Each accepted start pushes the hand-computed response onto a queue.
// Each instance has a monitor that pops and compares whenever done is asserted.
`timescale 1ns/1ps
module tb_serial_addsub_n;

    typedef struct {
        logic [47:0] res;
        logic        c;
        logic        v;
        int          lat;
        int          t0;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cycle;
    int   checks;
    int   errors;

    exp_t q_a[$];
    exp_t q_b[$];

    // DUT A signals (12-bit chunks, 4 chunks)
    logic        start_a, sub_a, in_valid_a;
    logic        in_ready_a, done_a, busy_a, carry_out_a, overflow_a;
    logic [11:0] in_a_a, in_b_a;
    logic [47:0] result_a;

    // DUT B signals (8-bit chunks, 2 chunks)
    logic        start_b, sub_b, in_valid_b;
    logic        in_ready_b, done_b, busy_b, carry_out_b, overflow_b;
    logic [7:0]  in_a_b, in_b_b;
    logic [15:0] result_b;

    logic prev_done_a;
    logic prev_done_b;

    serial_addsub_n #(.CHUNK_W(12), .NUM_CHUNKS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .sub(sub_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_a(in_a_a), .in_b(in_b_a),
        .result(result_a), .done(done_a), .busy(busy_a),
        .carry_out(carry_out_a), .overflow(overflow_a)
    );

    serial_addsub_n #(.CHUNK_W(8), .NUM_CHUNKS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sub(sub_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_a(in_a_b), .in_b(in_b_b),
        .result(result_b), .done(done_b), .busy(busy_b),
        .carry_out(carry_out_b), .overflow(overflow_b)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle index used for latency measurement
    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle = cycle + 1;
        end
    end

    // Hard stop in case something stalls forever
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor for DUT A: pops the scoreboard on every done
    initial begin
        prev_done_a = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done_a) begin
                checkOutput("a_done_pulse_width", prev_done_a, 1'b0);
                if (q_a.size() == 0) begin
                    checkOutput("a_unexpected_done", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    checkOutput("a_result", result_a, e.res);
                    checkOutput("a_carry_out", carry_out_a, e.c);
                    checkOutput("a_overflow", overflow_a, e.v);
                    checkOutput("a_latency", cycle - e.t0, e.lat);
                end
            end
            prev_done_a = done_a;
        end
    end

    // Monitor for DUT B: pops the scoreboard on every done
    initial begin
        prev_done_b = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done_b) begin
                checkOutput("b_done_pulse_width", prev_done_b, 1'b0);
                if (q_b.size() == 0) begin
                    checkOutput("b_unexpected_done", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    checkOutput("b_result", result_b, e.res);
                    checkOutput("b_carry_out", carry_out_b, e.c);
                    checkOutput("b_overflow", overflow_b, e.v);
                    checkOutput("b_latency", cycle - e.t0, e.lat);
                end
            end
            prev_done_b = done_b;
        end
    end

    // Wait (bounded) for an instance to return to IDLE
    task automatic waitIdle(input bit which_b);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!(which_b ? busy_b : busy_a)) begin
                idle = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput(which_b ? "b_return_idle" : "a_return_idle", idle, 1'b1);
    endtask

    // Drive one full operation into DUT A, optionally stalling after chunk stall_after
    task automatic applyStimulus(input logic [47:0] a, input logic [47:0] b, input logic s,
                                 input int stall_after, input int stall_len,
                                 input logic [47:0] er, input logic ec, input logic ev);
        exp_t e;
        @(negedge clk);
        start_a = 1'b1;
        sub_a   = s;
        e.res = er;
        e.c   = ec;
        e.v   = ev;
        e.t0  = cycle;
        e.lat = 5 + ((stall_after >= 0) ? stall_len : 0);
        q_a.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        sub_a   = ~s;
        checkOutput("a_flags_clear_c", carry_out_a, 1'b0);
        checkOutput("a_flags_clear_v", overflow_a, 1'b0);
        checkOutput("a_result_clear", result_a, 48'h0);
        checkOutput("a_in_ready_run", in_ready_a, 1'b1);
        for (int k = 0; k < 4; k++) begin
            in_a_a     = a[k*12 +: 12];
            in_b_a     = b[k*12 +: 12];
            in_valid_a = 1'b1;
            @(negedge clk);
            if (k == stall_after) begin
                in_valid_a = 1'b0;
                in_a_a     = 12'hABC;
                in_b_a     = 12'h555;
                repeat (stall_len) @(negedge clk);
            end
        end
        in_valid_a = 1'b0;
        waitIdle(1'b0);
        checkOutput("a_result_hold", result_a, er);
        checkOutput("a_carry_hold", carry_out_a, ec);
    endtask

    // Drive one full operation into DUT B; hold keeps start high through RUN and DONE
    task automatic applyStimulusB(input logic [15:0] a, input logic [15:0] b, input logic s,
                                  input bit hold, input logic [15:0] er,
                                  input logic ec, input logic ev);
        exp_t e;
        @(negedge clk);
        start_b = 1'b1;
        sub_b   = s;
        e.res = {32'h0, er};
        e.c   = ec;
        e.v   = ev;
        e.t0  = cycle;
        e.lat = 3;
        q_b.push_back(e);
        @(negedge clk);
        start_b = hold;
        sub_b   = ~s;
        checkOutput("b_busy_run", busy_b, 1'b1);
        for (int k = 0; k < 2; k++) begin
            in_a_b     = a[k*8 +: 8];
            in_b_b     = b[k*8 +: 8];
            in_valid_b = 1'b1;
            @(negedge clk);
        end
        in_valid_b = 1'b0;
        checkOutput("b_in_ready_done", in_ready_b, 1'b0);
        start_b = 1'b0;
        waitIdle(1'b1);
        if (hold) begin
            repeat (6) @(negedge clk);
            checkOutput("b_no_restart", busy_b, 1'b0);
        end
        checkOutput("b_result_hold", result_b, er);
    endtask

    // Main stimulus sequence
    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        start_a    = 1'b0; sub_a = 1'b0; in_valid_a = 1'b0; in_a_a = '0; in_b_a = '0;
        start_b    = 1'b0; sub_b = 1'b0; in_valid_b = 1'b0; in_a_b = '0; in_b_b = '0;
        #12;
        $display("[TB] checking reset state");
        checkOutput("rst_result", result_a, 48'h0);
        checkOutput("rst_done", done_a, 1'b0);
        checkOutput("rst_busy", busy_a, 1'b0);
        checkOutput("rst_in_ready", in_ready_a, 1'b0);
        checkOutput("rst_carry", carry_out_a, 1'b0);
        checkOutput("rst_overflow", overflow_a, 1'b0);
        checkOutput("rst_b_busy", busy_b, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_in_ready", in_ready_a, 1'b0);

        $display("[TB] add with full carry ripple");
        applyStimulus(48'hFFFFFFFFFFFF, 48'h000000000001, 1'b0, -1, 0, 48'h000000000000, 1'b1, 1'b0);
        $display("[TB] sub with borrow");
        applyStimulus(48'h000000000005, 48'h000000000007, 1'b1, -1, 0, 48'hFFFFFFFFFFFE, 1'b0, 1'b0);
        $display("[TB] add with signed overflow");
        applyStimulus(48'h7FFFFFFFFFFF, 48'h000000000001, 1'b0, -1, 0, 48'h800000000000, 1'b0, 1'b1);
        $display("[TB] add with 3-cycle stall");
        applyStimulus(48'h123456789ABC, 48'h111111111111, 1'b0, 1, 3, 48'h23456789ABCD, 1'b0, 1'b0);
        $display("[TB] sub with no final borrow");
        applyStimulus(48'h000000001000, 48'h000000000FFF, 1'b1, -1, 0, 48'h000000000001, 1'b1, 1'b0);

        $display("[TB] reset in the middle of an operation");
        @(negedge clk);
        start_a = 1'b1;
        sub_a   = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_a_a     = 12'h111;
            in_b_a     = 12'h222;
            in_valid_a = 1'b1;
            @(negedge clk);
        end
        in_valid_a = 1'b0;
        rst_n = 1'b0;
        #2;
        checkOutput("abort_result", result_a, 48'h0);
        checkOutput("abort_busy", busy_a, 1'b0);
        checkOutput("abort_done", done_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(48'h000000000002, 48'h000000000003, 1'b0, -1, 0, 48'h000000000005, 1'b0, 1'b0);

        $display("[TB] 8x2 build: sub with overflow, start held high");
        applyStimulusB(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        applyStimulusB(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        checkOutput("a_scoreboard_empty", q_a.size(), 0);
        checkOutput("b_scoreboard_empty", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
